// File: rtl/ram_pkg.sv
// Shared definitions for the ram_1rw_nr register-file RAM: the control
// state type, the byte-lane count helper and the word written by the
// post-reset clear sweep.
package ram_pkg;

    // CLEAR: post-reset sweep zeroing every entry; RUN: ports are live.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    // Widest data word the clear constant covers; instances slice it down.
    localparam int RAM_MAX_WIDTH = 4096;

    // Value written into every entry during the clear sweep.
    localparam logic [RAM_MAX_WIDTH-1:0] RAM_CLEAR_WORD = '0;

    // Number of byte lanes (and byte write enables) in a WIDTH-bit word.
    function automatic int ram_byte_count(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational per-byte merge used by the write-to-read bypass: each byte
// lane takes the new word where its enable is set, otherwise the old word.
// Only instantiated when RAM_BYPASS_EN is defined.
module ram_byte_merge
    import ram_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]   old_word,
    input  logic [WIDTH-1:0]   new_word,
    input  logic [WIDTH/8-1:0] be,
    output logic [WIDTH-1:0]   merged
);

    localparam int NBYTES = ram_byte_count(WIDTH);

    // Lane-by-lane select between stored and freshly written bytes.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_1rw_nr.sv
// ram_1rw_nr: register-file RAM with one read/write port (port 0) and NREAD
// read-only ports, byte write enables and a registered one-cycle read.
// After reset an internal sweep writes zero to every entry; READY rises on
// the edge that completes the last clear write.
//
// Build option: define RAM_BYPASS_EN to make a read whose address matches a
// same-cycle port-0 write return the per-byte merge of new and stored data.
// Without it, such reads return the pre-write contents and no comparators
// or merge muxes exist.
//
// Port semantics: there is no backpressure. While READY is high, every
// cycle with an enable high is an accepted access; the address and data are
// sampled at that edge and the read result appears on the output register
// after the same edge. While READY is low, enables are ignored. An output
// whose enable is low holds its previous value.
//
// The control state is held in 'state' (ram_state_t) for checkers to bind to.
module ram_1rw_nr
    import ram_pkg::*;
#(
    parameter int BITS  = 5,
    parameter int WIDTH = 64,
    parameter int NREAD = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    output logic                   READY,
    input  logic                   EN0,
    input  logic [BITS-1:0]        A0,
    input  logic [WIDTH/8-1:0]     WE0,
    input  logic [WIDTH-1:0]       Di0,
    output logic [WIDTH-1:0]       Do0,
    input  logic [NREAD-1:0]       EN_R,
    input  logic [NREAD*BITS-1:0]  A_R,
    output logic [NREAD*WIDTH-1:0] Do_R
);

    localparam int              NBYTES    = ram_byte_count(WIDTH);
    localparam int              DEPTH     = 2**BITS;
    localparam logic [BITS-1:0] LAST_ADDR = {BITS{1'b1}};

    logic [WIDTH-1:0] mem [DEPTH];
    ram_state_t       state;
    logic [BITS-1:0]  clr_cnt;

    // Clear sweep sequencing: restart from entry 0 on every reset edge and
    // enter RUN once the last entry has been written.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
                state <= RUN;
            end
        end
    end

    assign READY = (state == RUN);

    // Array writes: zero fill during the sweep, byte-masked port-0 writes in
    // RUN. Contents are deliberately left alone on a reset edge.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= RAM_CLEAR_WORD[WIDTH-1:0];
            end else if (EN0) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (WE0[i]) begin
                        mem[A0][8*i +: 8] <= Di0[8*i +: 8];
                    end
                end
            end
        end
    end

    // Port-0 read word; with bypass the write always targets A0, so the
    // merge uses WE0 directly.
    logic [WIDTH-1:0] rd0_old;
    logic [WIDTH-1:0] rd0_word;

    assign rd0_old = mem[A0];

`ifdef RAM_BYPASS_EN
    ram_byte_merge #(
        .WIDTH(WIDTH)
    ) u_merge0 (
        .old_word(rd0_old),
        .new_word(Di0),
        .be      (WE0),
        .merged  (rd0_word)
    );
`else
    assign rd0_word = rd0_old;
`endif

    // Port-0 output register: loads on enable in RUN, otherwise holds.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Do0 <= '0;
        end else if (state == RUN && EN0) begin
            Do0 <= rd0_word;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [BITS-1:0]  addr;
        logic [WIDTH-1:0] old_word;
        logic [WIDTH-1:0] rd_word;
        logic [WIDTH-1:0] q;

        assign addr     = A_R[k*BITS +: BITS];
        assign old_word = mem[addr];

`ifdef RAM_BYPASS_EN
        // Only bytes being written this cycle at this address are forwarded.
        logic [NBYTES-1:0] be;

        assign be = (EN0 && (addr == A0)) ? WE0 : '0;

        ram_byte_merge #(
            .WIDTH(WIDTH)
        ) u_merge (
            .old_word(old_word),
            .new_word(Di0),
            .be      (be),
            .merged  (rd_word)
        );
`else
        assign rd_word = old_word;
`endif

        // Read-port output register: loads on enable in RUN, otherwise holds.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                q <= '0;
            end else if (state == RUN && EN_R[k]) begin
                q <= rd_word;
            end
        end

        assign Do_R[k*WIDTH +: WIDTH] = q;
    end

endmodule
